vram8_blitter: RTL and testbench
================================

Name: vram8_blitter

Overview:
- Write-side engine for the 8-bit VRAM (tile index, color index and window tables, plus the scroll registers at 8192/8193).
- Fills or copies byte ranges in VRAM8 through the memory's second port, independent of the pixel renderer's read port.
- Programmed by the CPU-side memory-mapped interface: it supplies a start pulse plus descriptor and sees busy/done.
- Lets software clear or scroll whole tile planes without per-byte CPU writes.

Parameters:
ADDR_W, 14, VRAM8 address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, VRAM8 data width
LEN_W, 15, length width (max 16384 bytes = whole VRAM8)

Ports:
clk  in  1  system clock (GPU domain)
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = fill, 1 = copy; latched at start
src_addr  in  ADDR_W  copy source base; latched at start
dst_addr  in  ADDR_W  destination base; latched at start
length  in  LEN_W  byte count; latched at start
fill_value  in  DATA_W  fill byte; latched at start
vblank  in  1  vertical blanking indicator; used only with the optional feature
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when an operation completes
vram8_addr  out  ADDR_W  VRAM8 port-B address
vram8_d  out  DATA_W  VRAM8 port-B write data
vram8_we  out  1  VRAM8 port-B write enable
vram8_q  in  DATA_W  VRAM8 port-B read data, valid the cycle after the address is presented (synchronous RAM, 1-cycle latency)

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, vram8_we=0, vram8_addr=0, vram8_d=0; all latched descriptors and counters cleared.
- Reset mid-operation aborts immediately: vram8_we drops combinationally with reset and no done pulse is issued.
- States and transitions:
  - IDLE: on start with length==0, go to DONE (no VRAM access). On start with length>0, go to FILL or COPY_RD per mode.
  - FILL: each cycle present vram8_addr=dst, vram8_d=fill_value, vram8_we=1; then dst+=1 and remaining-=1. Go to DONE when remaining reaches 0.
  - COPY_RD: present vram8_addr=src, we=0; src+=1; go to COPY_WR.
  - COPY_WR: present vram8_addr=dst, vram8_d=vram8_q, we=1; dst+=1, remaining-=1. Go to DONE if remaining reaches 0, else COPY_RD.
  - DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- Cycle timing: start sampled at edge T. Fill writes occupy cycles T+1..T+N. Copy occupies T+1..T+2N (2 cycles/byte). done pulses at T+N+1 (fill) or T+2N+1 (copy).
- busy is high from T+1 through the last access cycle.
- start while busy or in DONE is ignored; inputs are not re-latched.
- Address arithmetic is ADDR_W bits, wrapping 0x3FFF→0x0000 on both src and dst.
- Copy is byte-sequential and forward, so overlapping ranges with dst>src replicate data. This is defined behaviour and is used for pattern fills.
- vram8_we is never high outside FILL/COPY_WR.

Optional Feature:
- Macro: VRAM8_BLITTER_VBLANK_ONLY_EN.
- With the macro: FILL and COPY_RD advance only in cycles where vblank=1. In other cycles the state holds, vram8_we=0 and busy stays 1. COPY_WR always completes once its read was issued, so the read data is not lost.
- Without the macro: vblank is ignored and accesses run back-to-back.

Decomposition:
- Shared package gpu_pkg holds:
  - VRAM8 constants: VRAM8_ADDR_W=14; base addresses BG_TILE=0, BG_COLOR=2048, WIN_TILE=4096, WIN_COLOR=6144, SCROLL_TILE=8192, SCROLL_FINE=8193.
  - BLIT_MODE_FILL/BLIT_MODE_COPY.
  - The state enumeration type.
- Single module; no sub-module needed.

Test Plan:
- Fill: mode=0, dst=0x1000, len=4, value=0x5A → writes 0x1000..0x1003=0x5A on cycles T+1..T+4; done at T+5; 0x0FFF and 0x1004 untouched.
- Copy: preload 0x0010..0x0012={11,22,33}; mode=1, src=0x0010, dst=0x0800, len=3 → 0x0800..0x0802={11,22,33}; done at T+7.
- Zero length: start with len=0 → no vram8_we at all; done at T+1; busy never asserted.
- Wrap: fill dst=0x3FFE, len=4, value=0xA5 → writes 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Overlap/ignored start: preload 0x0100=0x77; copy src=0x0100, dst=0x0101, len=3 → 0x0101..0x0103=0x77. A second start pulsed at T+2 is ignored, and only one done occurs.
- Reset mid-fill: len=100, assert reset_n=0 at T+10 → vram8_we=0 immediately, no done; after release busy=0 and a new fill works.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM8 address map, blitter modes and blitter state type.
package gpu_pkg;

    localparam int unsigned VRAM8_ADDR_W = 14;

    // VRAM8 table base addresses
    localparam logic [VRAM8_ADDR_W-1:0] BG_TILE     = 14'd0;
    localparam logic [VRAM8_ADDR_W-1:0] BG_COLOR    = 14'd2048;
    localparam logic [VRAM8_ADDR_W-1:0] WIN_TILE    = 14'd4096;
    localparam logic [VRAM8_ADDR_W-1:0] WIN_COLOR   = 14'd6144;
    localparam logic [VRAM8_ADDR_W-1:0] SCROLL_TILE = 14'd8192;
    localparam logic [VRAM8_ADDR_W-1:0] SCROLL_FINE = 14'd8193;

    localparam logic BLIT_MODE_FILL = 1'b0;
    localparam logic BLIT_MODE_COPY = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCopyRd,
        StCopyWr,
        StDone
    } blit_state_e;

endpackage

// File: rtl/vram8_blitter_if.sv
// VRAM8 port-B bus: the blitter is the master, the RAM is the slave.
interface vram8_blitter_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8
) ();

    logic [ADDR_W-1:0] vram8_addr;
    logic [DATA_W-1:0] vram8_d;
    logic              vram8_we;
    logic [DATA_W-1:0] vram8_q;  // synchronous read data, one cycle after address

    modport master (
        output vram8_addr,
        output vram8_d,
        output vram8_we,
        input  vram8_q
    );

    modport slave (
        input  vram8_addr,
        input  vram8_d,
        input  vram8_we,
        output vram8_q
    );

endinterface

// File: rtl/vram8_blitter.sv
// VRAM8 fill/copy engine driving the RAM's second port.
// Optional build macro VRAM8_BLITTER_VBLANK_ONLY_EN: fill writes and copy reads only
// advance while vblank=1; a copy write always completes once its read was issued.
module vram8_blitter
    import gpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              vblank,
    output logic              busy,
    output logic              done,
    vram8_blitter_if.master   vram
);

    blit_state_e       state_q;
    logic [ADDR_W-1:0] src_q, dst_q, addr_q;
    logic [LEN_W-1:0]  rem_q;   // bytes left after the access currently presented
    logic [DATA_W-1:0] fill_q, d_q;
    logic              we_q, busy_q, done_q;
    logic              advance;

`ifdef VRAM8_BLITTER_VBLANK_ONLY_EN
    assign advance = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign advance       = 1'b1;
`endif

    // Sequencer: state, address/length counters and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            d_q     <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        fill_q <= fill_value;
                        if (length == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (mode == BLIT_MODE_FILL) begin
                            // First write is presented in the very next cycle.
                            state_q <= StFill;
                            busy_q  <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= dst_addr;
                            d_q     <= fill_value;
                            dst_q   <= dst_addr + ADDR_W'(1);
                            rem_q   <= length - LEN_W'(1);
                        end else begin
                            state_q <= StCopyRd;
                            busy_q  <= 1'b1;
                            addr_q  <= src_addr;
                            src_q   <= src_addr + ADDR_W'(1);
                            rem_q   <= length;
                        end
                    end
                end
                StFill: begin
                    if (advance) begin
                        if (rem_q == '0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            we_q    <= 1'b0;
                        end else begin
                            addr_q <= dst_q;
                            d_q    <= fill_q;
                            dst_q  <= dst_q + ADDR_W'(1);
                            rem_q  <= rem_q - LEN_W'(1);
                        end
                    end
                end
                StCopyRd: begin
                    if (advance) begin
                        state_q <= StCopyWr;
                        addr_q  <= dst_q;
                        we_q    <= 1'b1;
                        dst_q   <= dst_q + ADDR_W'(1);
                        rem_q   <= rem_q - LEN_W'(1);
                    end
                end
                StCopyWr: begin
                    we_q <= 1'b0;
                    if (rem_q == '0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StCopyRd;
                        addr_q  <= src_q;
                        src_q   <= src_q + ADDR_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Copy data comes straight from the RAM's read port; it is only valid this cycle.
    assign vram.vram8_d    = (state_q == StCopyWr) ? vram.vram8_q : d_q;
    // A stalled fill cycle must not write.
    assign vram.vram8_we   = we_q & (advance | (state_q != StFill));
    assign vram.vram8_addr = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_vram8_blitter.sv
// Randomized scoreboard bench for vram8_blitter (default build, vblank ignored).
module tb_vram8_blitter;

    typedef struct {
        logic [13:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, mode, vblank;
    logic [13:0] src_addr, dst_addr;
    logic [14:0] length;
    logic [7:0]  fill_value;
    logic        busy, done;

    vram8_blitter_if #(.ADDR_W(14), .DATA_W(8)) vram ();

    vram8_blitter #(.ADDR_W(14), .DATA_W(8), .LEN_W(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .vblank     (vblank),
        .busy       (busy),
        .done       (done),
        .vram       (vram)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [16384];  // RAM seen by the DUT
    logic [7:0] mem_ref [16384];  // expected image

    // Synchronous single-cycle RAM on port B
    always @(posedge clk) begin
        if (vram.vram8_we) mem[vram.vram8_addr] <= vram.vram8_d;
        vram.vram8_q <= mem[vram.vram8_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    int  busy_lo = 0, busy_hi = 0, exp_done_cyc = 0;
    bit  done_armed = 0, done_seen = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented write, the done pulse and busy against the model.
    always @(negedge clk) begin
        wr_t w;
        check("busy", busy, (cyc >= busy_lo) && (cyc < busy_hi));
        if (vram.vram8_we) begin
            check("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("write_addr", vram.vram8_addr, w.a);
                check("write_data", vram.vram8_d, w.d);
                check("write_cycle", cyc, w.c);
            end
        end
        if (done) begin
            check("done_expected", done_armed, 1);
            check("done_cycle", cyc, exp_done_cyc);
            done_armed = 0;
            done_seen  = 1;
        end
    end

    // Issue one operation; the model applies bytes forward one at a time so overlapping
    // copies replicate. lim < len models an operation cut short by reset after lim
    // presented writes, of which the last one never commits.
    task automatic start_op(input logic m, input logic [13:0] s, input logic [13:0] dd,
                            input int len, input logic [7:0] f, input int lim,
                            input bit extra);
        int          t, dur;
        wr_t         w;
        logic [13:0] a, sa;
        logic [7:0]  v;
        @(negedge clk);
        t   = cyc + 1;
        dur = (len == 0) ? 0 : (m ? 2 * len : len);
        busy_lo      = t;
        busy_hi      = t + dur;
        exp_done_cyc = t + dur;
        done_armed   = (lim == len);
        done_seen    = 0;
        for (int i = 0; i < lim; i++) begin
            a  = dd + 14'(i);
            sa = s + 14'(i);
            v  = m ? mem_ref[sa] : f;
            w.a = a;
            w.d = v;
            w.c = t + (m ? 2 * i + 1 : i);
            exp_q.push_back(w);
            if (lim == len || i < lim - 1) mem_ref[a] = v;
        end
        mode = m; src_addr = s; dst_addr = dd; length = 15'(len); fill_value = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (extra) begin
            @(negedge clk);
            start = 1'b1; mode = ~m; src_addr = 14'($urandom); dst_addr = 14'($urandom);
            length = 15'd5; fill_value = 8'hEE;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done_seen; i++) @(posedge clk);
        check("done_seen", done_seen, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic mem_compare(input string name);
        int bad = 0;
        for (int i = 0; i < 16384; i++) if (mem[i] !== mem_ref[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    always @(negedge clk) vblank = 1'($urandom_range(0, 1));

    initial begin
        int len;
        logic m;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_value = '0;
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 8'($urandom);
            mem_ref[i] = mem[i];
        end
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_we", vram.vram8_we, 0);
        check("reset_addr", vram.vram8_addr, 0);
        check("reset_d", vram.vram8_d, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Fill 4 bytes at 0x1000
        start_op(1'b0, 14'h0, 14'h1000, 4, 8'h5A, 4, 0);
        wait_done(20);
        check("fill_below_untouched", mem[14'h0FFF], mem_ref[14'h0FFF]);
        check("fill_above_untouched", mem[14'h1004], mem_ref[14'h1004]);

        // Copy 3 preloaded bytes
        @(negedge clk);
        mem[14'h10] = 8'h11; mem[14'h11] = 8'h22; mem[14'h12] = 8'h33;
        mem_ref[14'h10] = 8'h11; mem_ref[14'h11] = 8'h22; mem_ref[14'h12] = 8'h33;
        start_op(1'b1, 14'h0010, 14'h0800, 3, 8'h00, 3, 0);
        wait_done(20);
        check("copy_byte2", mem[14'h0802], 8'h33);

        // Zero length
        start_op(1'b0, 14'h0, 14'h2000, 0, 8'hFF, 0, 0);
        wait_done(10);

        // Destination wrap
        start_op(1'b0, 14'h0, 14'h3FFE, 4, 8'hA5, 4, 0);
        wait_done(20);
        check("wrap_byte0", mem[14'h0000], 8'hA5);

        // Overlapping forward copy with an ignored second start
        @(negedge clk);
        mem[14'h100] = 8'h77; mem_ref[14'h100] = 8'h77;
        start_op(1'b1, 14'h0100, 14'h0101, 3, 8'h00, 3, 1);
        wait_done(20);
        check("overlap_byte3", mem[14'h0103], 8'h77);
        mem_compare("mem_image_directed");

        // Reset in the tenth cycle of a 100-byte fill
        start_op(1'b0, 14'h0, 14'h0400, 100, 8'h3C, 10, 0);
        for (int i = 0; i < 40 && cyc < busy_lo + 9; i++) @(negedge clk);
        check("reset_point_reached", cyc, busy_lo + 9);
        #2;
        reset_n = 1'b0;
        busy_hi = 0;
        #1;
        check("we_in_reset", vram.vram8_we, 0);
        check("busy_in_reset", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", done_seen, 0);
        check("reset_queue_drained", exp_q.size(), 0);
        start_op(1'b0, 14'h0, 14'h0500, 6, 8'hC3, 6, 0);
        wait_done(20);
        mem_compare("mem_image_after_reset");

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(0, 24);
            m   = 1'($urandom);
            start_op(m, 14'($urandom), 14'($urandom), len, 8'($urandom), len,
                     (len >= 3) && ($urandom_range(0, 1) == 1));
            wait_done(2 * len + 10);
        end
        repeat (4) @(negedge clk);
        mem_compare("mem_image_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
